// File: rtl/cp0_if.sv
// cp0 bus: M-stage access/trap signals between the core and coprocessor 0.
// master = core side (drives requests), slave = cp0 (drives trap/read data).
interface cp0_if;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code_in;
    logic [31:0] badvaddr_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] dout;
    logic [31:0] handler;

    modport master (
        output we, a1, a2, din, pc, bd, exc_code_in,
        output badvaddr_in, hw_int, eret,
        input  req, epc_out, dout, handler
    );

    modport slave (
        input  we, a1, a2, din, pc, bd, exc_code_in,
        input  badvaddr_in, hw_int, eret,
        output req, epc_out, dout, handler
    );
endinterface

// File: rtl/cp0.sv
// cp0: interrupt/exception responder with SR/Cause/EPC/PRId (+BadVAddr).
// Ports: clk, reset (sync, active-high), bus (cp0_if.slave).
// Optional: define CP0_BADVADDR_EN to add BadVAddr (reg 8).
module cp0 #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h2020_0706
) (
    input logic clk,
    input logic reset,
    cp0_if.slave bus
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] pc_al;
    logic [31:0] epc_d;
    logic [4:0]  exc_d;
    logic [31:0] dout_d;

    assign int_req = (|(bus.hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = (bus.exc_code_in != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;

    assign pc_al = {bus.pc[31:2], 2'b00};
    // Delay-slot traps restart at the branch, one word back.
    assign epc_d = bus.bd ? pc_al - 32'd4 : pc_al;
    assign exc_d = int_req ? 5'd0 : bus.exc_code_in;

`ifdef CP0_BADVADDR_EN
    logic [31:0] badv_q;
    logic        unused_ok;
    assign unused_ok = ^bus.pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            badv_q <= '0;
        end else if (exc_req & ~int_req &
                     (bus.exc_code_in == 5'd4 ||
                      bus.exc_code_in == 5'd5)) begin
            badv_q <= bus.badvaddr_in;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{bus.pc[1:0], bus.badvaddr_in};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            ip_q <= bus.hw_int;
            if (req) begin
                exl_q <= 1'b1;
                bd_q  <= bus.bd;
                exc_q <= exc_d;
                epc_q <= epc_d;
            end else begin
                if (bus.eret) begin
                    exl_q <= 1'b0;
                end
                // An mtc0 to SR in the eret cycle wins over eret.
                if (bus.we) begin
                    case (bus.a2)
                        5'd12: begin
                            im_q  <= bus.din[15:10];
                            exl_q <= bus.din[1];
                            ie_q  <= bus.din[0];
                        end
                        5'd14: epc_q <= {bus.din[31:2], 2'b00};
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        dout_d = '0;
        case (bus.a1)
`ifdef CP0_BADVADDR_EN
            5'd8:  dout_d = badv_q;
`endif
            5'd12: dout_d = {16'h0, im_q, 8'h0, exl_q, ie_q};
            5'd13: dout_d = {bd_q, 15'h0, ip_q, 3'h0, exc_q, 2'h0};
            5'd14: dout_d = epc_q;
            5'd15: dout_d = PRID_VALUE;
            default: dout_d = '0;
        endcase
    end

    assign bus.req     = req;
    assign bus.epc_out = epc_q;
    assign bus.dout    = dout_d;
    assign bus.handler = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed vector table plus randomized run against a word-level
// model of the CP0 register file.
module tb_cp0;

    logic clk;
    logic reset;
    cp0_if ifc ();

    cp0 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed;
    int total;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    logic [31:0] m_badv;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        ereq;
        logic [31:0] edout;
        logic [31:0] eepc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic m_int();
        return (((ifc.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1]);
    endfunction

    function automatic logic m_req();
        return m_int() || (ifc.exc_code_in != 5'd0 && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_badv;
`endif
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h2020_0706;
            default: return 32'h0;
        endcase
    endfunction

    // Applied at the rising edge with the inputs that were held that cycle.
    task automatic m_step();
        logic r;
        logic i;
        logic [31:0] code;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_badv = 0;
            return;
        end
        r = m_req();
        i = m_int();
        if (r) begin
            code = i ? 0 : ifc.exc_code_in;
            if (!i && (ifc.exc_code_in == 4 || ifc.exc_code_in == 5))
                m_badv = ifc.badvaddr_in;
            m_sr = m_sr | 32'h2;
            m_cause = (ifc.bd ? 32'h8000_0000 : 0) + (ifc.hw_int * 1024) + code * 4;
            m_epc = (ifc.pc & ~32'h3) - (ifc.bd ? 4 : 0);
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | (ifc.hw_int * 1024);
            if (ifc.eret) m_sr = m_sr & ~32'h2;
            if (ifc.we && ifc.a2 == 12) m_sr = ifc.din & 32'h0000_FC03;
            if (ifc.we && ifc.a2 == 14) m_epc = ifc.din & ~32'h3;
        end
    endtask

    task automatic clock();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        reset           = v.rst;
        ifc.we          = v.we;
        ifc.a1          = v.a1;
        ifc.a2          = v.a2;
        ifc.din         = v.din;
        ifc.pc          = v.pc;
        ifc.bd          = v.bd;
        ifc.exc_code_in = v.exc;
        ifc.hw_int      = v.hw;
        ifc.eret        = v.eret;
        ifc.badvaddr_in = 32'hdead_beef;
    endtask

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [4:0] a1,
        input logic [4:0] a2, input logic [31:0] din, input logic [31:0] pc,
        input logic bd, input logic [4:0] exc, input logic [5:0] hw,
        input logic eret, input logic ereq, input logic [31:0] edout,
        input logic [31:0] eepc);
        vec_t v;
        v.rst = rst; v.we = we; v.a1 = a1; v.a2 = a2; v.din = din;
        v.pc = pc; v.bd = bd; v.exc = exc; v.hw = hw; v.eret = eret;
        v.ereq = ereq; v.edout = edout; v.eepc = eepc;
        return v;
    endfunction

    logic [4:0] regs [6];

    initial begin
        passed = 0;
        total  = 0;
        regs[0] = 8; regs[1] = 12; regs[2] = 13;
        regs[3] = 14; regs[4] = 15; regs[5] = 3;

        //           rst we a1  a2  din           pc            bd exc hw    er  req dout          epc
        tbl.push_back(mk(0, 0, 12, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 15, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h2020_0706, 32'h0));
        tbl.push_back(mk(0, 1, 12, 12, 32'h401,     0,            0, 0,  6'd0, 0, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 12, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h401,       32'h0));
        tbl.push_back(mk(0, 0, 13, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h1000,      32'h0));
        tbl.push_back(mk(0, 1, 13, 12, 32'h1001,    0,            0, 0,  6'd0, 0, 0, 32'h1000,      32'h0));
        tbl.push_back(mk(0, 0, 12, 0, 0,            32'h30b4,     0, 0,  6'd4, 0, 1, 32'h1001,      32'h0));
        tbl.push_back(mk(0, 0, 14, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h30b4,      32'h30b4));
        tbl.push_back(mk(0, 0, 13, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h1000,      32'h30b4));
        tbl.push_back(mk(0, 0, 12, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h1003,      32'h30b4));
        tbl.push_back(mk(0, 0, 12, 0, 0,            0,            0, 0,  6'd4, 1, 0, 32'h1003,      32'h30b4));
        tbl.push_back(mk(0, 0, 12, 0, 0,            32'h3200,     1, 12, 6'd4, 0, 1, 32'h1001,      32'h30b4));
        tbl.push_back(mk(0, 0, 13, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h8000_1000, 32'h31fc));
        tbl.push_back(mk(0, 0, 14, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h31fc,      32'h31fc));
        tbl.push_back(mk(0, 1, 12, 12, 32'h0,       0,            0, 0,  6'd0, 0, 0, 32'h1003,      32'h31fc));
        tbl.push_back(mk(0, 0, 12, 0, 0,            32'h4000,     0, 10, 6'd0, 0, 1, 32'h0,         32'h31fc));
        tbl.push_back(mk(0, 0, 13, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h28,        32'h4000));
        tbl.push_back(mk(0, 1, 12, 12, 32'h0,       0,            0, 0,  6'd0, 0, 0, 32'h2,         32'h4000));
        tbl.push_back(mk(0, 1, 14, 14, 32'h3007,    32'h5000,     0, 10, 6'd0, 0, 1, 32'h4000,      32'h4000));
        tbl.push_back(mk(0, 1, 14, 14, 32'h3007,    0,            0, 0,  6'd0, 0, 0, 32'h5000,      32'h5000));
        tbl.push_back(mk(0, 0, 14, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h3004,      32'h3004));
        tbl.push_back(mk(0, 1, 8,  13, 32'hffff_ffff, 0,          0, 0,  6'd0, 0, 0, 32'h0,         32'h3004));
        tbl.push_back(mk(0, 0, 13, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h28,        32'h3004));
        tbl.push_back(mk(0, 1, 12, 12, 32'h1001,    0,            0, 0,  6'd0, 0, 0, 32'h2,         32'h3004));
        tbl.push_back(mk(1, 0, 12, 0, 0,            32'h6000,     0, 5,  6'd4, 0, 1, 32'h1001,      32'h3004));
        tbl.push_back(mk(0, 0, 12, 0, 0,            0,            0, 0,  6'd4, 0, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 13, 0, 0,            0,            0, 0,  6'd0, 0, 0, 32'h1000,      32'h0));

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0));
        @(negedge clk);
        clock();
        clock();

        check("handler", ifc.handler, 32'h0000_4180);

        foreach (tbl[k]) begin
            apply(tbl[k]);
            #1;
            check($sformatf("row%0d.req", k), {31'h0, ifc.req}, {31'h0, tbl[k].ereq});
            check($sformatf("row%0d.dout", k), ifc.dout, tbl[k].edout);
            check($sformatf("row%0d.epc", k), ifc.epc_out, tbl[k].eepc);
            clock();
        end

        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            ifc.we          = ($urandom_range(0, 3) == 0);
            ifc.a1          = regs[$urandom_range(0, 5)];
            ifc.a2          = regs[$urandom_range(0, 5)];
            ifc.din         = $urandom;
            ifc.pc          = $urandom;
            ifc.bd          = $urandom_range(0, 1);
            ifc.exc_code_in = ($urandom_range(0, 4) == 0) ?
                              5'($urandom_range(1, 31)) : 5'd0;
            ifc.hw_int      = ($urandom_range(0, 2) == 0) ?
                              6'($urandom) : 6'd0;
            ifc.eret        = ($urandom_range(0, 3) == 0);
            ifc.badvaddr_in = $urandom;
            #1;
            check("rnd.req", {31'h0, ifc.req}, {31'h0, m_req()});
            check("rnd.dout", ifc.dout, m_read(ifc.a1));
            check("rnd.epc", ifc.epc_out, m_epc);
            clock();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
